bkm_iter_engine: RTL and testbench
==================================

Name: bkm_iter_engine

Overview:
- Iterative BKM E-mode engine. Runs a complete sequence of BKM steps on one set of operands, one step per enabled clock, with a start/done handshake.
- Generalises the single bkm_step to a run-time iteration count (1..N), uses internal digit selection (d_n computed from u/v residuals), and adds an external LUT read port, a stall enable and a sticky overflow flag.
- Sits between the FPU operand formatter and the result normaliser in xfire_fpu_bkm. All datapaths are two's complement Q2.F, where F = W-2.

Parameters:
- W, 16, datapath width for X, Y, u, v (fractional bits F = W-2).
- N, 12, maximum iteration count; must satisfy N <= 2^LOG2N - 1.
- LOG2N, 4, width of the iteration index.

Ports:
- clk  in  1  clock.
- arst  in  1  reset, synchronous, active-high.
- ena  in  1  step enable; when low the engine stalls and holds all state.
- start  in  1  start request; accepted only when busy=0.
- iters  in  LOG2N  iteration count, latched at start; 0 or >N is treated as N.
- X0, Y0  in  W each  initial complex operand.
- u0, v0  in  W each  initial complex residual.
- lut_n  out  LOG2N  LUT address: current step index n.
- lut_dx, lut_dy  out  2 each  LUT address: digit code, 2'b01=+1, 2'b11=-1, 2'b00=0.
- lut_u, lut_v  in  W each  combinational LUT data, Re/Im of ln(1+d·2^-n); sampled in the same cycle it is addressed.
- X, Y, u, v  out  W each  result registers.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when results become valid.
- ovf  out  1  sticky overflow flag for X/Y over the current operation.

Behaviour:
- Reset: all registers 0; state IDLE; busy=done=ovf=0; lut_n=0, lut_dx=lut_dy=0.
- States:
  - IDLE: when start=1, load X,Y,u,v from X0,Y0,u0,v0; latch iters; set n=1; clear ovf; go to RUN.
  - RUN, ena=1: perform one step at the clock edge. If n == latched iters, go to DONE; else n <= n+1.
  - RUN, ena=0: hold everything, including n and the state.
  - DONE: done=1 for exactly this one cycle; then go to IDLE. A start in DONE is accepted exactly as in IDLE, so back-to-back operations are possible.
- start while busy=1 is ignored, with no side effect.
- Digit selection (combinational from current u, v, n):
  - h_n = 1 << max(F-n-1, 0).
  - dx = +1 if u >= h_n; -1 if u <= -h_n; else 0.
  - dy is the same rule applied to v.
- Step update, with s(a) = a >>> n (arithmetic shift); all operations are W-bit two's complement and wrap:
  - X' = X + dx·s(X) - dy·s(Y).
  - Y' = Y + dx·s(Y) + dy·s(X).
  - u' = u - lut_u if (dx,dy) != (0,0); otherwise u is unchanged (LUT data ignored).
  - v' = v - lut_v under the same condition.
- Overflow: ovf is set if any X/Y add or subtract within a step exceeds the signed W-bit range. Results wrap; ovf stays set until the next accepted start. u/v are not checked.
- LUT port: lut_n, lut_dx and lut_dy are valid throughout RUN and are 0 outside RUN.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+iters_eff, plus one cycle per stalled (ena=0) cycle.
- Results: X, Y, u, v stay stable from done until the next accepted start.
- Reset mid-operation: operation abandoned; all outputs return to their reset values on the next cycle.
- Simultaneous arst and start: arst wins.

Test Plan:
- Identity case (W=16, F=14): X0=16384, Y0=u0=v0=0, iters=4, ena=1 → all digits 0; done exactly 5 cycles after start; X=16384, Y=0, u=v=0, ovf=0.
- Single step: X0=16384, Y0=0, u0=8192, v0=0, iters=1, LUT returns lut_u=3656, lut_v=0 for (n=1,+1,0) → lut_dx=01, lut_dy=00; X=24576, Y=0, u=4536, v=0; done 2 cycles after start.
- Stall: repeat the single-step case with iters=3 and ena low for 3 cycles mid-run → done delayed by exactly 3 cycles; results identical to the unstalled run; lut_n holds its value during the stall.
- Overflow: X0=32767, Y0=0, u0=8192, iters=1, lut_u=3656 → X=-16386 (wrapped), ovf=1. A following start with in-range operands clears ovf.
- Reset mid-run: iters=8, arst asserted after step 2 → next cycle busy=done=ovf=0 and X=Y=u=v=0. A new start then completes normally.
- iters=0 and start while busy: iters=0 → lut_n steps 1..12 and done after 12 steps. A start pulse at step 5 is ignored: no reload, and done timing is unchanged.

Source files
------------

// File: rtl/bkm_iter_engine.sv
// Iterative BKM E-mode engine: one BKM step per enabled clock on Q2.F complex operands,
// with internal digit selection, an external LUT read port and a sticky X/Y overflow flag.
module bkm_iter_engine #(
   parameter int W     = 16,
   parameter int N     = 12,
   parameter int LOG2N = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             ena,
   input  logic             start,
   input  logic [LOG2N-1:0] iters,
   input  logic [W-1:0]     X0,
   input  logic [W-1:0]     Y0,
   input  logic [W-1:0]     u0,
   input  logic [W-1:0]     v0,
   output logic [LOG2N-1:0] lut_n,
   output logic [1:0]       lut_dx,
   output logic [1:0]       lut_dy,
   input  logic [W-1:0]     lut_u,
   input  logic [W-1:0]     lut_v,
   output logic [W-1:0]     X,
   output logic [W-1:0]     Y,
   output logic [W-1:0]     u,
   output logic [W-1:0]     v,
   output logic             busy,
   output logic             done,
   output logic             ovf
);
   localparam int F = W - 2;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     x_q, x_d, y_q, y_d, u_q, u_d, v_q, v_d;
   logic [LOG2N-1:0] n_q, n_d, iters_q, iters_d;
   logic             busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;

   // Digit threshold h_n = 2^max(F-n-1, 0)
   int               h_shamt;
   logic signed [W-1:0] h_n;
   always_comb begin
      h_shamt = F - 1 - int'(n_q);
      if (h_shamt < 0) h_shamt = 0;
      h_n = {{(W-1){1'b0}}, 1'b1} << h_shamt;
   end

   logic dx_pos, dx_neg, dy_pos, dy_neg, dx_any, dy_any;
   assign dx_pos = $signed(u_q) >= h_n;
   assign dx_neg = $signed(u_q) <= -h_n;
   assign dy_pos = $signed(v_q) >= h_n;
   assign dy_neg = $signed(v_q) <= -h_n;
   assign dx_any = dx_pos | dx_neg;
   assign dy_any = dy_pos | dy_neg;

   logic signed [W-1:0] sx, sy;
   assign sx = $signed(x_q) >>> n_q;
   assign sy = $signed(y_q) >>> n_q;

   // Returns {overflow, wrapped result} of a W-bit signed add or subtract.
   function automatic logic [W:0] addsub(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
      logic [W-1:0] r;
      logic         o;
      r = sub ? (a - b) : (a + b);
      o = sub ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
              : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
      return {o, r};
   endfunction

   // A zero digit selects a zero operand, which can never overflow.
   logic [W-1:0] x_t, y_t, x_new, y_new;
   logic [3:0]   step_ovf;
   assign {step_ovf[0], x_t}   = addsub(x_q, dx_any ? sx : '0, dx_neg);
   assign {step_ovf[1], x_new} = addsub(x_t, dy_any ? sy : '0, dy_pos);
   assign {step_ovf[2], y_t}   = addsub(y_q, dx_any ? sy : '0, dx_neg);
   assign {step_ovf[3], y_new} = addsub(y_t, dy_any ? sx : '0, dy_neg);

   logic [LOG2N-1:0] iters_eff;
   assign iters_eff = (iters == '0 || iters > LOG2N'(N)) ? LOG2N'(N) : iters;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      u_d     = u_q;
      v_d     = v_q;
      n_d     = n_q;
      iters_d = iters_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_RUN: begin
            if (ena) begin
               x_d   = x_new;
               y_d   = y_new;
               ovf_d = ovf_q | (|step_ovf);
               if (dx_any || dy_any) begin
                  u_d = u_q - lut_u;
                  v_d = v_q - lut_v;
               end
               if (n_q == iters_q) state_d = S_DONE;
               else                n_d     = n_q + LOG2N'(1);
            end
         end
         default: begin
            // IDLE and DONE both accept a start, allowing back-to-back operations.
            state_d = S_IDLE;
            if (start) begin
               x_d     = X0;
               y_d     = Y0;
               u_d     = u0;
               v_d     = v0;
               iters_d = iters_eff;
               n_d     = LOG2N'(1);
               ovf_d   = 1'b0;
               state_d = S_RUN;
            end
         end
      endcase
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         u_q     <= '0;
         v_q     <= '0;
         n_q     <= '0;
         iters_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         u_q     <= u_d;
         v_q     <= v_d;
         n_q     <= n_d;
         iters_q <= iters_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   // LUT address is driven only while running so the table sees a quiet bus otherwise.
   assign lut_n  = busy_q ? n_q : '0;
   assign lut_dx = busy_q ? (dx_pos ? 2'b01 : (dx_neg ? 2'b11 : 2'b00)) : 2'b00;
   assign lut_dy = busy_q ? (dy_pos ? 2'b01 : (dy_neg ? 2'b11 : 2'b00)) : 2'b00;

   assign X    = x_q;
   assign Y    = y_q;
   assign u    = u_q;
   assign v    = v_q;
   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;
endmodule

// File: tb/tb_bkm_iter_engine.sv
// Bench for bkm_iter_engine: directed cases with literal expectations plus random operations,
// all tracked by an operation-level reference model checked every cycle.
module tb_bkm_iter_engine;
   localparam int W = 16, N = 12, LOG2N = 4, F = W - 2;

   logic        clk = 1'b0, arst = 1'b1, ena = 1'b1, start = 1'b0;
   logic [3:0]  iters = '0;
   logic [15:0] x0_s = '0, y0_s = '0, u0_s = '0, v0_s = '0;
   logic [3:0]  lut_n;
   logic [1:0]  lut_dx, lut_dy;
   logic [15:0] lut_u, lut_v;
   logic [15:0] X, Y, u, v;
   logic        busy, done, ovf;

   bkm_iter_engine #(.W(W), .N(N), .LOG2N(LOG2N)) dut (
      .clk(clk), .arst(arst), .ena(ena), .start(start), .iters(iters),
      .X0(x0_s), .Y0(y0_s), .u0(u0_s), .v0(v0_s),
      .lut_n(lut_n), .lut_dx(lut_dx), .lut_dy(lut_dy), .lut_u(lut_u), .lut_v(lut_v),
      .X(X), .Y(Y), .u(u), .v(v), .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int sx16(input int a);
      return {{16{a[15]}}, a[15:0]};
   endfunction

   function automatic int dec(input logic [1:0] c);
      return (c == 2'b01) ? 1 : ((c == 2'b11) ? -1 : 0);
   endfunction

   function automatic int enc(input int d);
      return (d == 1) ? 1 : ((d == -1) ? 3 : 0);
   endfunction

   // Stand-in LUT; zero-digit entries return junk that the engine must ignore.
   function automatic int lut_re(input int n, input int dx, input int dy);
      if (dx == 0 && dy == 0) return 4660;
      if (n == 1 && dx == 1 && dy == 0) return 3656;
      return sx16(dx * (12000 >> n) + ((n * 37 + dy * 5) & 31));
   endfunction

   function automatic int lut_im(input int n, input int dx, input int dy);
      if (dx == 0 && dy == 0) return -291;
      if (n == 1 && dx == 1 && dy == 0) return 0;
      return sx16(dy * (12867 >> n) + ((n * 11 + dx * 3) & 15));
   endfunction

   always_comb begin
      lut_u = 16'(lut_re(int'(lut_n), dec(lut_dx), dec(lut_dy)));
      lut_v = 16'(lut_im(int'(lut_n), dec(lut_dx), dec(lut_dy)));
   end

   // Reference model: a whole operation is evaluated at acceptance into a step plan
   // and final results; the per-cycle view only tracks progress through the plan.
   int plan_n[16], plan_dx[16], plan_dy[16];
   int m_len = 0, m_k = 0;
   bit m_busy = 0, m_done = 0;
   int exp_x = 0, exp_y = 0, exp_u = 0, exp_v = 0, exp_ovf = 0;

   task automatic compute_plan(input int x0, input int y0, input int u0, input int v0, input int it);
      int x, y, uu, vv, h, dx, dy, sxv, syv, t, xn, yn, ite;
      ite = (it == 0 || it > N) ? N : it;
      x = x0; y = y0; uu = u0; vv = v0;
      exp_ovf = 0;
      for (int n = 1; n <= ite; n++) begin
         h  = 1 << (((F - n - 1) > 0) ? (F - n - 1) : 0);
         dx = (uu >= h) ? 1 : ((uu <= -h) ? -1 : 0);
         dy = (vv >= h) ? 1 : ((vv <= -h) ? -1 : 0);
         plan_n[n-1] = n; plan_dx[n-1] = dx; plan_dy[n-1] = dy;
         sxv = x >>> n;
         syv = y >>> n;
         t = x + dx * sxv;  if (t > 32767 || t < -32768) exp_ovf = 1;
         t = sx16(t) - dy * syv; if (t > 32767 || t < -32768) exp_ovf = 1;
         xn = sx16(t);
         t = y + dx * syv;  if (t > 32767 || t < -32768) exp_ovf = 1;
         t = sx16(t) + dy * sxv; if (t > 32767 || t < -32768) exp_ovf = 1;
         yn = sx16(t);
         if (dx != 0 || dy != 0) begin
            uu = sx16(uu - lut_re(n, dx, dy));
            vv = sx16(vv - lut_im(n, dx, dy));
         end
         x = xn; y = yn;
      end
      m_len = ite;
      exp_x = x; exp_y = y; exp_u = uu; exp_v = vv;
   endtask

   // Compare on the falling edge, then advance the model with the inputs the next rising edge sees.
   initial begin
      forever begin
         @(negedge clk);
         chk("busy", int'(busy), int'(m_busy));
         chk("done", int'(done), int'(m_done));
         if (m_busy) begin
            chk("lut_n", int'(lut_n), plan_n[m_k]);
            chk("lut_dx", int'(lut_dx), enc(plan_dx[m_k]));
            chk("lut_dy", int'(lut_dy), enc(plan_dy[m_k]));
         end else begin
            chk("lut_n_idle", int'(lut_n), 0);
            chk("lut_d_idle", int'({lut_dx, lut_dy}), 0);
            chk("X", int'($signed(X)), exp_x);
            chk("Y", int'($signed(Y)), exp_y);
            chk("u", int'($signed(u)), exp_u);
            chk("v", int'($signed(v)), exp_v);
            chk("ovf", int'(ovf), exp_ovf);
         end
         if (arst) begin
            m_busy = 0; m_done = 0; m_k = 0;
            exp_x = 0; exp_y = 0; exp_u = 0; exp_v = 0; exp_ovf = 0;
         end else if (m_busy) begin
            m_done = 0;
            if (ena) begin
               if (m_k == m_len - 1) begin m_busy = 0; m_done = 1; end
               else m_k++;
            end
         end else begin
            m_done = 0;
            if (start) begin
               compute_plan(int'($signed(x0_s)), int'($signed(y0_s)), int'($signed(u0_s)),
                            int'($signed(v0_s)), int'(iters));
               m_busy = 1; m_k = 0;
            end
         end
      end
   end

   int first_n, first_dx, first_dy;

   // Called #1 after a rising edge; start is raised immediately so a DONE cycle can accept it.
   task automatic run_op(input int x0, input int y0, input int u0, input int v0, input int it,
                         input int stall_at, input int stall_len, input int busy_start_at,
                         input bit rnd_ena, output int lat);
      x0_s = 16'(x0); y0_s = 16'(y0); u0_s = 16'(u0); v0_s = 16'(v0);
      iters = 4'(it); start = 1'b1; ena = 1'b1; lat = 0;
      while (1) begin
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
         if (lat == 1) begin
            first_n = int'(lut_n); first_dx = int'(lut_dx); first_dy = int'(lut_dy);
         end
         if (done) break;
         if (lat > 400) begin
            n_total++;
            $display("FAIL op_timeout: no done after %0d cycles, required within 400", lat);
            break;
         end
         if (rnd_ena) ena = ($urandom_range(0, 3) != 0);
         else ena = !(lat >= stall_at && lat < stall_at + stall_len);
         if (lat == busy_start_at) begin
            start = 1'b1;
            x0_s = 16'($urandom); u0_s = 16'($urandom); iters = 4'($urandom_range(0, 15));
         end
      end
      ena = 1'b1;
      start = 1'b0;
   endtask

   initial begin
      int lat;
      repeat (3) @(posedge clk);
      #1 arst = 1'b0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_X", int'(X), 0);
      chk("rst_lut_n", int'(lut_n), 0);

      run_op(16384, 0, 0, 0, 4, 0, 0, 0, 0, lat);
      chk("ident_lat", lat, 5);
      chk("ident_X", int'($signed(X)), 16384);
      chk("ident_u", int'($signed(u)), 0);
      chk("ident_ovf", int'(ovf), 0);

      run_op(16384, 0, 8192, 0, 1, 0, 0, 0, 0, lat);
      chk("single_lat", lat, 2);
      chk("single_lut_n", first_n, 1);
      chk("single_lut_dx", first_dx, 1);
      chk("single_lut_dy", first_dy, 0);
      chk("single_X", int'($signed(X)), 24576);
      chk("single_Y", int'($signed(Y)), 0);
      chk("single_u", int'($signed(u)), 4536);
      chk("single_v", int'($signed(v)), 0);

      run_op(16384, 0, 8192, 0, 3, 0, 0, 0, 0, lat);
      chk("nostall_lat", lat, 4);
      run_op(16384, 0, 8192, 0, 3, 2, 3, 0, 0, lat);
      chk("stall_lat", lat, 7);

      run_op(32767, 0, 8192, 0, 1, 0, 0, 0, 0, lat);
      chk("ovf_X", int'($signed(X)), -16386);
      chk("ovf_set", int'(ovf), 1);
      run_op(16384, 0, 8192, 0, 1, 0, 0, 0, 0, lat);
      chk("ovf_clear", int'(ovf), 0);
      chk("ovf_clear_X", int'($signed(X)), 24576);

      // Reset after two steps of an eight-step run.
      x0_s = 16'd12345; y0_s = 16'd2222; u0_s = 16'd6000; v0_s = 16'hE000;
      iters = 4'd8; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 arst = 1'b1;
      @(posedge clk); #1 arst = 1'b0;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_ovf", int'(ovf), 0);
      chk("mid_rst_XYuv", int'({X, Y} | {u, v}), 0);
      run_op(16384, 0, 8192, 0, 1, 0, 0, 0, 0, lat);
      chk("post_rst_X", int'($signed(X)), 24576);

      run_op(16384, 1000, 5000, -3000, 0, 0, 0, 5, 0, lat);
      chk("iters0_lat", lat, 13);

      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom), int'($urandom), int'($urandom_range(0, 24000)) - 12000,
                int'($urandom_range(0, 24000)) - 12000, int'($urandom_range(0, 15)),
                0, 0, int'($urandom_range(0, 20)), 1'b1, lat);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
